// File: rtl/im_prefetch_queue.sv
// Instruction prefetch queue: streams sequential SRAM reads into a DEPTH-entry {pc, inst} FIFO.
// Define IMPQ_BYPASS_EN to forward a response straight to the fetch stage when the queue is empty.
module im_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        if_ready,
  output logic        if_valid,
  output logic [15:0] if_pc,
  output logic [31:0] if_inst,
  output logic        im_ceb,
  output logic [15:0] im_addr,
  input  logic [31:0] im_rdata
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [15:0]   pc_mem_q   [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [15:0]   inflight_pc_q, inflight_pc_d;
  logic          drop_q, drop_d;

  logic redir, credit, issue, resp, head_valid, push, pop;

  // Combinational outputs are gated by rst so the SRAM sees no strobe while in reset.
  assign redir      = redirect_valid & rst;
  assign credit     = (count_q + CW'(inflight_q)) < CW'(DEPTH);
  assign issue      = rst & (redir | credit);
  assign im_ceb     = ~issue;
  assign im_addr    = redir ? {redirect_pc[15:2], 2'b00} : fetch_pc_q;
  assign resp       = inflight_q & ~drop_q & ~redir;
  assign head_valid = (count_q != '0);
  assign pop        = head_valid & if_ready & ~redir;

`ifdef IMPQ_BYPASS_EN
  logic byp;
  assign byp      = resp & ~head_valid;
  assign push     = resp & ~(byp & if_ready);
  assign if_valid = head_valid | byp;
  assign if_pc    = head_valid ? pc_mem_q[rd_ptr_q]   : (byp ? inflight_pc_q : '0);
  assign if_inst  = head_valid ? inst_mem_q[rd_ptr_q] : (byp ? im_rdata      : '0);
`else
  assign push     = resp;
  assign if_valid = head_valid;
  assign if_pc    = head_valid ? pc_mem_q[rd_ptr_q]   : '0;
  assign if_inst  = head_valid ? inst_mem_q[rd_ptr_q] : '0;
`endif

  always_comb begin
    fetch_pc_d    = issue ? im_addr + 16'd4 : fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = issue ? im_addr : inflight_pc_q;
    drop_d        = ~issue;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    if (redir) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      drop_q        <= 1'b1;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      drop_q        <= drop_d;
    end
  end

  // Storage needs no reset: entries are only visible when count says so.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
      inst_mem_q[wr_ptr_q] <= im_rdata;
    end
  end

endmodule

// File: tb/tb_im_prefetch_queue.sv
// Scoreboard bench for im_prefetch_queue: stimulus queues expected PCs, a monitor checks each delivery.
module tb_im_prefetch_queue;

`ifdef IMPQ_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        if_ready = 1'b0;
  logic        if_valid;
  logic [15:0] if_pc;
  logic [31:0] if_inst;
  logic        im_ceb;
  logic [15:0] im_addr;
  logic [31:0] im_rdata = '0;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_next = '0;
  logic [15:0] mon_e;
  int cyc;

  im_prefetch_queue #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_ready(if_ready), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .im_ceb(im_ceb), .im_addr(im_addr), .im_rdata(im_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [15:0] pc);
    return 32'h1000_0000 + {18'd0, pc[15:2]};
  endfunction

  // SRAM model: word n holds 0x1000_0000 + n, one-cycle read latency.
  always @(posedge clk) begin
    if (!im_ceb) im_rdata <= word_of(im_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && if_valid && if_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_delivery: got pc %h expected none", if_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("deliver_pc", 32'(if_pc), 32'(mon_e));
        chk("deliver_inst", if_inst, word_of(mon_e));
      end
    end
  end

  // Accept exactly n entries; called just after a rising edge.
  task automatic take(input int n, output int cycles);
    int got;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(exp_next);
      exp_next = exp_next + 16'd4;
    end
    if_ready = 1'b1;
    got = 0;
    cycles = 0;
    while (got < n && cycles < 200) begin
      @(negedge clk);
      if (if_valid) got++;
      cycles++;
      @(posedge clk);
      #1;
    end
    if_ready = 1'b0;
    if (got < n) chk("take_timeout", 32'(got), 32'(n));
  endtask

  task automatic redirect_cycle(input logic [15:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", 32'(if_pc), 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    chk("rst_im_ceb", 32'(im_ceb), 32'd1);
    chk("rst_im_addr", 32'(im_addr), 32'h0000);

    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("latency_t1_valid", 32'(if_valid), 32'(BYP));
    @(negedge clk);
    chk("latency_t2_valid", 32'(if_valid), 32'd1);
    chk("latency_t2_pc", 32'(if_pc), 32'h0000);

    repeat (10) @(negedge clk);
    chk("stall_ceb", 32'(im_ceb), 32'd1);
    chk("stall_valid", 32'(if_valid), 32'd1);
    @(negedge clk);
    chk("stall_ceb_hold", 32'(im_ceb), 32'd1);

    @(posedge clk);
    #1;
    take(8, cyc);
    chk("throughput_cycles", 32'(cyc), 32'd8);

    redirect_valid = 1'b1;
    redirect_pc    = 16'h0102;
    exp_next       = 16'h0100;
    #1;
    chk("redir_addr", 32'(im_addr), 32'h0100);
    chk("redir_ceb", 32'(im_ceb), 32'd0);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    take(2, cyc);

    repeat (3) @(posedge clk);
    #1;
    redirect_cycle(16'h0040);
    redirect_cycle(16'h0080);
    exp_next = 16'h0080;
    take(2, cyc);

    redirect_cycle(16'hFFF8);
    exp_next = 16'hFFF8;
    take(4, cyc);

    repeat (6) @(posedge clk);
    #1;
    chk("pre_reset_valid", 32'(if_valid), 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_if_valid", 32'(if_valid), 32'd0);
    chk("midrst_im_ceb", 32'(im_ceb), 32'd1);
    chk("midrst_im_addr", 32'(im_addr), 32'h0000);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_next = 16'h0000;
    take(3, cyc);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
